// File: rtl/sdram_rfifo_pkg.sv
// Shared constants and types for the SDRAM read-data FIFO.
// The constants sit next to the SDRAM data-lane width so that all users share one value.
package sdram_rfifo_pkg;

    localparam int DQ_BITS        = 8;
    localparam int RFIFO_DW       = DQ_BITS;
    localparam int RFIFO_DEPTH    = 16;
    localparam int RFIFO_AW       = 4;
    localparam int RFIFO_AFULL_TH = 12;

    // Accepted operations in one cycle, written as {write accepted, pop accepted}.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_POP   = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } rfifo_op_e;

endpackage

// File: rtl/sdram_rfifo_mem.sv
// DEPTH x DW register-file storage for the read-data FIFO.
// It has a synchronous write port and an asynchronous read port.
module sdram_rfifo_mem
    import sdram_rfifo_pkg::*;
#(
    parameter int DW    = RFIFO_DW,
    parameter int DEPTH = RFIFO_DEPTH,
    parameter int AW    = RFIFO_AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];

    // The storage is never reset. Stale entries are unreachable once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sdram_rfifo.sv
// Read-data FIFO downstream of the SDRAM read engine.
// It captures CAS-aligned read bytes and drains them to the consumer with occupancy and sticky error status.
module sdram_rfifo
    import sdram_rfifo_pkg::*;
#(
    parameter int DW       = RFIFO_DW,
    parameter int DEPTH    = RFIFO_DEPTH,
    parameter int AW       = RFIFO_AW,
    parameter int AFULL_TH = RFIFO_AFULL_TH
) (
    input  logic          sdram_clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          empty,
    output logic          full,
    output logic          almost_full,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic          underflow,
    input  logic          clr_err
);

    localparam logic [AW:0]   LVL_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_AFULL = (AW+1)'(AFULL_TH);
    localparam logic [AW:0]   LVL_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic          pop_ok;
    logic          wr_ok;
    rfifo_op_e     op;
    logic [DW-1:0] mem_rdata;

    sdram_rfifo_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (sdram_clk),
        .we    (wr_ok),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    always_comb begin
        // A pop only needs the registered empty flag. A write into a full FIFO
        // is accepted when a pop in the same cycle frees a slot.
        pop_ok = rd_en && !empty_q;
        wr_ok  = wr_en && (!full_q || pop_ok);
        op     = rfifo_op_e'({wr_ok, pop_ok});

        wr_ptr_d = wr_ok  ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        level_d = level_q;
        case (op)
            OP_WRITE: level_d = level_q + LVL_ONE;
            OP_POP:   level_d = level_q - LVL_ONE;
            default:  level_d = level_q;
        endcase

        empty_d = (level_d == '0);
        full_d  = (level_d == LVL_FULL);
        afull_d = (level_d >= LVL_AFULL);

        rd_data_d  = pop_ok ? mem_rdata : rd_data_q;
        rd_valid_d = pop_ok;

        // A new error event outranks clr_err in the same cycle.
        ovf_d = ovf_q;
        if (wr_en && !wr_ok) begin
            ovf_d = 1'b1;
        end else if (clr_err) begin
            ovf_d = 1'b0;
        end

        udf_d = udf_q;
        if (rd_en && empty_q) begin
            udf_d = 1'b1;
        end else if (clr_err) begin
            udf_d = 1'b0;
        end
    end

    always_ff @(posedge sdram_clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            afull_q    <= afull_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign empty       = empty_q;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign level       = level_q;
    assign overflow    = ovf_q;
    assign underflow   = udf_q;

endmodule

// File: tb/tb_sdram_rfifo.sv
// Scoreboard bench for sdram_rfifo. A queue-based FIFO model predicts status and popped data.
// A separate monitor checks every rd_valid word against the expected-data queue.
module tb_sdram_rfifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int AFTH  = 12;

    logic          sdram_clk = 1'b0;
    logic          rst       = 1'b0;
    logic          wr_en     = 1'b0;
    logic [DW-1:0] wr_data   = '0;
    logic          rd_en     = 1'b0;
    logic          clr_err   = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic [AW:0]   level;
    logic          overflow;
    logic          underflow;

    int checks = 0;
    int errors = 0;

    // Reference model state: contents in FIFO order, sticky flags, and the words the consumer must receive.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] expq[$];
    bit            m_ovf = 0;
    bit            m_udf = 0;
    bit            m_pop = 0;

    sdram_rfifo #(
        .DW       (DW),
        .DEPTH    (DEPTH),
        .AW       (AW),
        .AFULL_TH (AFTH)
    ) dut (
        .sdram_clk   (sdram_clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .level       (level),
        .overflow    (overflow),
        .underflow   (underflow),
        .clr_err     (clr_err)
    );

    always #5 sdram_clk = ~sdram_clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, ".level"},    int'(level),       mq.size());
        chk({tag, ".empty"},    int'(empty),       int'(mq.size() == 0));
        chk({tag, ".full"},     int'(full),        int'(mq.size() == DEPTH));
        chk({tag, ".afull"},    int'(almost_full), int'(mq.size() >= AFTH));
        chk({tag, ".overflow"}, int'(overflow),    int'(m_ovf));
        chk({tag, ".underflow"},int'(underflow),   int'(m_udf));
        chk({tag, ".rd_valid"}, int'(rd_valid),    int'(m_pop));
    endtask

    // One clock cycle. The model applies the FIFO rules before the edge, and the DUT is sampled 1 time unit after it.
    task automatic step(input bit wr, input logic [DW-1:0] wd, input bit rd, input bit clr, input string tag);
        bit mempty, mfull, acc_w;
        wr_en   = wr;
        wr_data = wd;
        rd_en   = rd;
        clr_err = clr;
        mempty  = (mq.size() == 0);
        mfull   = (mq.size() == DEPTH);
        m_pop   = rd && !mempty;
        acc_w   = wr && (!mfull || m_pop);
        if (m_pop) expq.push_back(mq.pop_front());
        if (acc_w) mq.push_back(wd);
        if (wr && !acc_w) m_ovf = 1;
        else if (clr)     m_ovf = 0;
        if (rd && mempty) m_udf = 1;
        else if (clr)     m_udf = 0;
        @(posedge sdram_clk);
        #1;
        chk_status(tag);
    endtask

    task automatic do_reset(input bit wr, input bit rd);
        rst     = 1'b1;
        wr_en   = wr;
        wr_data = 8'hE5;
        rd_en   = rd;
        clr_err = 1'b0;
        mq.delete();
        m_ovf = 0;
        m_udf = 0;
        m_pop = 0;
        @(posedge sdram_clk);
        #1;
        rst = 1'b0;
        chk_status("reset");
        chk("reset.rd_data", int'(rd_data), 0);
    endtask

    task automatic idle(input string tag);
        step(0, 8'h00, 0, 0, tag);
    endtask

    // Monitor: every word the DUT presents must be the oldest outstanding expected word.
    always @(posedge sdram_clk) begin
        #1;
        if (rd_valid) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got rd_data 0x%0h, expected no word at %0t", rd_data, $time);
            end else begin
                logic [DW-1:0] e;
                e = expq.pop_front();
                if (rd_data !== e) begin
                    errors++;
                    $display("FAIL rd_data: got 0x%0h expected 0x%0h at %0t", rd_data, e, $time);
                end
            end
        end
    end

    initial begin
        do_reset(1, 1);

        // 1: four writes, then four pops
        for (int i = 0; i < 4; i++) step(1, 8'h11 + 8'(i), 0, 0, "t1.wr");
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, "t1.rd");
        idle("t1.end");

        // 2: fill, overflow, drain
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, "t2.fill");
        step(1, 8'hAA, 0, 0, "t2.ovf");
        for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, "t2.drain");
        step(0, 8'h00, 0, 1, "t2.clr");

        // 3: simultaneous write and pop while full
        for (int i = 0; i < 16; i++) step(1, 8'h40 + 8'(i), 0, 0, "t3.fill");
        step(1, 8'h55, 1, 0, "t3.both");
        for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, "t3.drain");
        idle("t3.end");

        // 4: simultaneous write and pop while empty, then clr_err
        step(1, 8'h77, 1, 0, "t4.both");
        step(0, 8'h00, 1, 0, "t4.rd");
        step(0, 8'h00, 0, 1, "t4.clr");
        // An error event in the same cycle as clr_err keeps the flag set.
        step(0, 8'h00, 1, 1, "t4.clr_vs_evt");
        step(0, 8'h00, 0, 1, "t4.clr2");

        // 5: streaming through the wrap, level kept in 1..8
        begin
            int nw = 0;
            logic [DW-1:0] b = 8'hC0;
            while (nw < 40) begin
                bit w, r;
                w = (mq.size() < 8) && ($urandom_range(0, 3) != 0);
                r = (mq.size() > 1) && ($urandom_range(0, 1) != 0);
                if (mq.size() == 0) w = 1;
                step(w, b, r, 0, "t5.stream");
                if (w) begin
                    nw++;
                    b++;
                end
            end
            while (mq.size() > 0) step(0, 8'h00, 1, 0, "t5.drain");
            idle("t5.end");
        end

        // 6: reset with level 9 mid-stream, then a single write/pop
        for (int i = 0; i < 9; i++) step(1, 8'h90 + 8'(i), 0, 0, "t6.fill");
        do_reset(1, 1);
        step(1, 8'h3C, 0, 0, "t6.wr");
        step(0, 8'h00, 1, 0, "t6.rd");
        idle("t6.end");

        // Random traffic, including full/empty corners and clr_err collisions
        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = (i / 100) % 3;
            step($urandom_range(0, 9) < (bias == 0 ? 7 : (bias == 1 ? 3 : 5)),
                 8'($urandom),
                 $urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 7 : 5)),
                 $urandom_range(0, 15) == 0,
                 "rand");
        end
        while (mq.size() > 0) step(0, 8'h00, 1, 0, "final.drain");
        idle("final.idle");

        chk("expq_drained", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
